// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo
//   Scans a ROWS x COLS matrix keypad with active-low row strobes. The column
//   returns are synchronised and debounced. Each accepted press or release is
//   queued as an event in a first-word fall-through FIFO.
//
// Ports
//   clk, rst_n         single clock, asynchronous active-low reset
//   row_drive          active-low row strobe, exactly one bit low
//   col_in             raw active-low column returns (asynchronous)
//   ev_valid/ev_ready  pop handshake for the event FIFO head
//   ev_code            head key index (row*COLS + col), 0 when empty
//   ev_release         head event type (0 press, 1 release), 0 when empty
//   fifo_count         current FIFO occupancy
//   key_held           a key is accepted and not yet released
//   held_code          code of the held key, 0 otherwise
//   overflow           sticky: an event was dropped because the FIFO was full
//   clr_overflow       synchronous clear of overflow (a same-cycle drop wins)
module keypad_scan_fifo #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned SCAN_DELAY = 200000,
    parameter int unsigned DB_CYCLES  = 65536,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned KW        = $clog2(ROWS * COLS),
    localparam int unsigned CNTW      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [ROWS-1:0] row_drive,
    input  logic [COLS-1:0] col_in,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [KW-1:0]   ev_code,
    output logic            ev_release,
    output logic [CNTW-1:0] fifo_count,
    output logic            key_held,
    output logic [KW-1:0]   held_code,
    output logic            overflow,
    input  logic            clr_overflow
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned TW = $clog2(SCAN_DELAY);
    localparam int unsigned DW = $clog2(DB_CYCLES);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0]   TimerReload = TW'(SCAN_DELAY - 1);
    localparam logic [DW-1:0]   DbLast      = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0]   RowLast     = RW'(ROWS - 1);
    localparam logic [2:0]      SettleLoad  = 3'd4;
    localparam logic [CNTW-1:0] FifoFull    = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StScan, StDbPress, StHeld, StDbRel} state_e;

    state_e          state_q, state_d;
    logic [COLS-1:0] col_meta_q, col_s_q;
    logic [RW-1:0]   row_q, row_d, row_next;
    logic [ROWS-1:0] row_drive_q, row_drive_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      settle_q, settle_d;
    logic [DW-1:0]   db_cnt_q, db_cnt_d;
    logic [COLS-1:0] cap_q, cap_d;
    logic [KW-1:0]   held_code_q, held_code_d;
    logic            key_held_q, key_held_d;
    logic [CW-1:0]   cap_col;
    logic [KW-1:0]   cap_code;
    logic            all_ones;

    logic            push, push_rel;
    logic [KW-1:0]   push_code;

    logic [KW:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            pop, wr_en, drop;
    logic [KW:0]     head;

    assign all_ones = &col_s_q;
    assign row_next = (row_q == RowLast) ? '0 : row_q + RW'(1);

    // Lowest-index low column of the captured pattern wins.
    always_comb begin
        cap_col = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!cap_q[i]) cap_col = CW'(i);
        end
        cap_code = KW'(32'(row_q) * COLS + 32'(cap_col));
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        timer_d     = timer_q;
        settle_d    = (settle_q != 3'd0) ? settle_q - 3'd1 : settle_q;
        db_cnt_d    = db_cnt_q;
        cap_d       = cap_q;
        held_code_d = held_code_q;
        push        = 1'b0;
        push_rel    = 1'b0;
        push_code   = '0;
        unique case (state_q)
            StScan: begin
                // col_s still reflects the previous row until settle expires.
                if (settle_q == 3'd0 && !all_ones) begin
                    cap_d    = col_s_q;
                    db_cnt_d = '0;
                    state_d  = StDbPress;
                end else if (timer_q == '0) begin
                    row_d    = row_next;
                    timer_d  = TimerReload;
                    settle_d = SettleLoad;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StDbPress: begin
                if (col_s_q != cap_q) begin
                    state_d = StScan;
                    timer_d = TimerReload;
                end else if (db_cnt_q == DbLast) begin
                    push        = 1'b1;
                    push_code   = cap_code;
                    held_code_d = cap_code;
                    state_d     = StHeld;
                end else begin
                    db_cnt_d = db_cnt_q + DW'(1);
                end
            end
            StHeld: begin
                // Other columns changing while held are ignored: first key wins.
                if (all_ones) begin
                    db_cnt_d = '0;
                    state_d  = StDbRel;
                end
            end
            StDbRel: begin
                if (!all_ones) begin
                    state_d = StHeld;
                end else if (db_cnt_q == DbLast) begin
                    push        = 1'b1;
                    push_rel    = 1'b1;
                    push_code   = held_code_q;
                    held_code_d = '0;
                    state_d     = StScan;
                    row_d       = row_next;
                    timer_d     = TimerReload;
                    settle_d    = SettleLoad;
                end else begin
                    db_cnt_d = db_cnt_q + DW'(1);
                end
            end
            default: state_d = StScan;
        endcase
        key_held_d  = (state_d == StHeld) || (state_d == StDbRel);
        row_drive_d = ~(ROWS'(1) << row_d);
    end

    // FIFO: a push into a full FIFO is accepted only if the head leaves this cycle.
    always_comb begin
        pop        = (count_q != '0) && ev_ready;
        wr_en      = push && ((count_q != FifoFull) || pop);
        drop       = push && (count_q == FifoFull) && !pop;
        wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop) count_d = count_q + CNTW'(1);
        if (!wr_en && pop) count_d = count_q - CNTW'(1);
        overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q  <= '1;
            col_s_q     <= '1;
            state_q     <= StScan;
            row_q       <= '0;
            row_drive_q <= ~ROWS'(1);
            timer_q     <= TimerReload;
            settle_q    <= SettleLoad;
            db_cnt_q    <= '0;
            cap_q       <= '1;
            held_code_q <= '0;
            key_held_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            col_meta_q  <= col_in;
            col_s_q     <= col_meta_q;
            state_q     <= state_d;
            row_q       <= row_d;
            row_drive_q <= row_drive_d;
            timer_q     <= timer_d;
            settle_q    <= settle_d;
            db_cnt_q    <= db_cnt_d;
            cap_q       <= cap_d;
            held_code_q <= held_code_d;
            key_held_q  <= key_held_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {push_rel, push_code};
    end

    assign head       = mem_q[rd_ptr_q];
    assign ev_valid   = (count_q != '0);
    assign ev_code    = ev_valid ? head[KW-1:0] : '0;
    assign ev_release = ev_valid & head[KW];
    assign row_drive  = row_drive_q;
    assign fifo_count = count_q;
    assign key_held   = key_held_q;
    assign held_code  = held_code_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Testbench for keypad_scan_fifo: a physical key-matrix model drives col_in from
// row_drive, and an event-level reference model predicts the event stream.
module tb_keypad_scan_fifo;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int SCAN_DELAY = 8;
    localparam int DB_CYCLES  = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int KW         = 4;
    localparam int LAT        = DB_CYCLES + 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [ROWS-1:0] row_drive;
    logic [COLS-1:0] col_in;
    logic            ev_valid;
    logic            ev_ready;
    logic [KW-1:0]   ev_code;
    logic            ev_release;
    logic [2:0]      fifo_count;
    logic            key_held;
    logic [KW-1:0]   held_code;
    logic            overflow;
    logic            clr_overflow = 1'b0;

    logic [ROWS*COLS-1:0] pressed = '0;
    bit rand_ready  = 1'b0;
    bit fixed_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic          rel;
        logic [KW-1:0] code;
    } ev_t;
    ev_t exp_q[$];
    bit  model_ovf = 1'b0;

    keypad_scan_fifo #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .SCAN_DELAY(SCAN_DELAY),
        .DB_CYCLES (DB_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_drive   (row_drive),
        .col_in      (col_in),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_release  (ev_release),
        .fifo_count  (fifo_count),
        .key_held    (key_held),
        .held_code   (held_code),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column; only the driven (low) row shows.
    always_comb begin
        col_in = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (pressed[r*COLS+c] && !row_drive[r]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void commit(input logic rel, input logic [KW-1:0] code);
        ev_t e;
        e.rel  = rel;
        e.code = code;
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(e);
        else model_ovf = 1'b1;
    endfunction

    // ev_ready changes just after posedge so the negedge scoreboard sees the pop decision.
    initial begin
        ev_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ev_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
        end
    end

    // Consumer-side scoreboard: every popped head must match the model in order.
    always @(negedge clk) begin
        if (rst_n && ev_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_event", 32'(ev_valid), 32'd0);
            end else if (ev_ready) begin
                check_eq("ev_code", 32'(ev_code), 32'(exp_q[0].code));
                check_eq("ev_release", 32'(ev_release), 32'(exp_q[0].rel));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_row_drive"}, 32'(row_drive), 32'(4'b1110));
        check_eq({tag, "_ev_valid"}, 32'(ev_valid), 32'd0);
        check_eq({tag, "_ev_code"}, 32'(ev_code), 32'd0);
        check_eq({tag, "_ev_release"}, 32'(ev_release), 32'd0);
        check_eq({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check_eq({tag, "_key_held"}, 32'(key_held), 32'd0);
        check_eq({tag, "_held_code"}, 32'(held_code), 32'd0);
        check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // Called right after reset release: row k/SCAN_DELAY is driven after posedge k.
    task automatic check_scan(input int cycles);
        logic [ROWS-1:0] one;
        logic [ROWS-1:0] exp;
        one = 4'b0001;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            exp = ~(one << ((k / SCAN_DELAY) % ROWS));
            check_eq("row_drive_scan", 32'(row_drive), 32'(exp));
        end
    endtask

    // Returns at the first negedge after the strobe moves onto row r.
    task automatic align_row(input int r);
        logic [ROWS-1:0] one;
        logic [ROWS-1:0] target;
        logic [ROWS-1:0] prev;
        bit found;
        one    = 4'b0001;
        target = ~(one << r);
        prev   = row_drive;
        found  = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (row_drive == target && prev != target) found = 1'b1;
            prev = row_drive;
        end
        if (!found) check_eq("align_row_timeout", 32'(row_drive), 32'(target));
    endtask

    task automatic wait_held(input logic level, output int n);
        n = 0;
        while (key_held !== level && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic key_cycle(input int r, input int c, input int hold, input bit bounce);
        int k;
        int n;
        logic [KW-1:0] code;
        k    = r * COLS + c;
        code = KW'(k);
        align_row(r);
        repeat (2) @(negedge clk);
        #1 pressed[k] = 1'b1;
        if (bounce) begin
            for (int i = 1; i <= 5; i++) begin
                repeat (5) @(negedge clk);
                #1 pressed[k] = (i % 2 == 0);
            end
            repeat (5) @(negedge clk);
            check_eq("bounce_no_hold", 32'(key_held), 32'd0);
            #1 pressed[k] = 1'b1;
        end
        commit(1'b0, code);
        wait_held(1'b1, n);
        check_eq("press_latency", n, LAT);
        check_eq("press_valid", 32'(ev_valid), 32'd1);
        check_eq("held_code", 32'(held_code), 32'(code));
        repeat ((hold > n) ? hold - n : 1) @(negedge clk);
        #1 pressed[k] = 1'b0;
        commit(1'b1, code);
        wait_held(1'b0, n);
        check_eq("release_latency", n, LAT);
        check_eq("held_code_clear", 32'(held_code), 32'd0);
    endtask

    initial begin
        int r, ca, cb, n, w;
        logic [KW-1:0] code;

        // Reset and idle sweep
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        #1 rst_n = 1'b1;
        check_scan(5 * SCAN_DELAY);
        check_eq("idle_valid", 32'(ev_valid), 32'd0);

        // Clean presses with a randomly stalling consumer
        rand_ready = 1'b1;
        key_cycle(2, 1, 40, 1'b0);
        repeat (3) begin
            key_cycle(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)),
                      int'($urandom_range(DB_CYCLES + 6, DB_CYCLES + 24)), 1'b0);
        end

        // Bouncing contact
        key_cycle(int'($urandom_range(0, ROWS - 1)), 0, 40, 1'b1);
        key_cycle(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)),
                  40, 1'b1);

        // Two keys on one row: lowest column wins, partial release is ignored
        r  = int'($urandom_range(0, ROWS - 1));
        ca = int'($urandom_range(0, COLS - 2));
        cb = int'($urandom_range(ca + 1, COLS - 1));
        code = KW'(r * COLS + ca);
        align_row(r);
        repeat (2) @(negedge clk);
        #1 begin
            pressed[r*COLS+ca] = 1'b1;
            pressed[r*COLS+cb] = 1'b1;
        end
        commit(1'b0, code);
        wait_held(1'b1, n);
        check_eq("multi_press_latency", n, LAT);
        check_eq("multi_held_code", 32'(held_code), 32'(code));
        repeat (10) @(negedge clk);
        #1 pressed[r*COLS+cb] = 1'b0;
        repeat (DB_CYCLES + 10) @(negedge clk);
        check_eq("multi_still_held", 32'(key_held), 32'd1);
        check_eq("multi_still_code", 32'(held_code), 32'(code));
        #1 pressed[r*COLS+ca] = 1'b0;
        commit(1'b1, code);
        wait_held(1'b0, n);
        check_eq("multi_release_latency", n, LAT);

        // Drain everything before the overflow scenario
        rand_ready  = 1'b0;
        fixed_ready = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("drain1_left", 32'(exp_q.size()), 32'd0);
        check_eq("drain1_count", 32'(fifo_count), 32'd0);

        // Overflow: six events into four slots with the consumer stalled
        fixed_ready = 1'b0;
        repeat (2) @(negedge clk);
        repeat (3) begin
            key_cycle(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)),
                      int'($urandom_range(DB_CYCLES + 6, DB_CYCLES + 24)), 1'b0);
        end
        repeat (5) @(negedge clk);
        check_eq("ovf_count", 32'(fifo_count), 32'(exp_q.size()));
        check_eq("ovf_flag", 32'(overflow), 32'(model_ovf));
        check_eq("ovf_head_code", 32'(ev_code), 32'(exp_q[0].code));
        check_eq("ovf_head_rel", 32'(ev_release), 32'(exp_q[0].rel));
        #1 clr_overflow = 1'b1;
        @(negedge clk);
        model_ovf = 1'b0;
        check_eq("ovf_cleared", 32'(overflow), 32'(model_ovf));
        #1 clr_overflow = 1'b0;
        fixed_ready = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("drain2_left", 32'(exp_q.size()), 32'd0);
        check_eq("drain2_count", 32'(fifo_count), 32'd0);

        // Reset in the middle of a press debounce, with events pending
        fixed_ready = 1'b0;
        repeat (2) @(negedge clk);
        key_cycle(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)),
                  40, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("pre_reset_count", 32'(fifo_count), 32'(exp_q.size()));
        r  = int'($urandom_range(0, ROWS - 1));
        ca = int'($urandom_range(0, COLS - 1));
        w  = int'($urandom_range(5, 12));
        align_row(r);
        repeat (2) @(negedge clk);
        #1 pressed[r*COLS+ca] = 1'b1;
        repeat (w) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_reset");
        exp_q.delete();
        model_ovf = 1'b0;
        pressed   = '0;
        fixed_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        check_scan(2 * SCAN_DELAY);
        repeat (40) @(negedge clk);
        check_eq("post_reset_valid", 32'(ev_valid), 32'd0);
        check_eq("post_reset_count", 32'(fifo_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
